// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the multiply/divide unit and the E-stage op decode:
//   - md_op_e      : md_op encoding (NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   - *_CYCLES_DEF : default busy latencies for multiply and divide
//   - md_result_t  : {hi, lo} pair produced by the arithmetic
//   - md_is_muldiv : true for ops that occupy the unit over multiple cycles
// -----------------------------------------------------------------------------
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic md_is_muldiv(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
// Loadable down-counter that produces the unit's busy indication.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load_i     : load load_val_i into the counter this edge
//   load_val_i : latency to load (number of busy cycles)
//   clear_i    : force the counter to zero (wins over load and decrement)
//   busy_o     : counter != 0, taken straight from the register
//   done_o     : high during the final busy cycle; the coming edge moves the
//                counter 1 -> 0, so the owner commits its result on that edge
// -----------------------------------------------------------------------------
module md_busy_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             clear_i,
    output logic             busy_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    // A clear on the final edge suppresses the commit.
    assign done_o = (cnt_q == CNT_W'(1)) && !clear_i;

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// E-stage multiply/divide unit with HI/LO registers.  MULT/MULTU/DIV/DIVU
// compute their result at the start edge into a pending register and commit
// it to HI/LO on the edge where busy falls.  MTHI/MTLO write in one cycle.
//
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   cancel  : (MD_CANCEL_EN only) flush the in-flight op, no commit
//   start   : one-cycle pulse launching md_op
//   md_op   : md_op_e encoding
//   A, B    : rs / rt operands
//   busy    : high while a mult/div is in flight
//   hi_out  : current HI
//   lo_out  : current LO
//
// Build option: define MD_CANCEL_EN to add the cancel input.
// -----------------------------------------------------------------------------
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MD_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // ---------------------------------------------------------------------
    // Arithmetic helpers
    // ---------------------------------------------------------------------
    function automatic md_result_t mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        p  = sa * sb;
        return '{hi: p[63:32], lo: p[31:0]};
    endfunction

    function automatic md_result_t mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return '{hi: p[63:32], lo: p[31:0]};
    endfunction

    // Signed division goes through magnitudes so that truncation toward zero
    // and dividend-signed remainder fall out directly; 0x80000000 / -1 yields
    // quotient 0x80000000 (two's-complement wrap) and remainder 0.
    // A zero divisor returns the current HI/LO so the commit is a no-op.
    function automatic md_result_t divide(input logic [31:0] a, input logic [31:0] b,
                                          input logic is_signed, input md_result_t cur);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            return cur;
        end
        mag_a = (is_signed && a[31]) ? (~a + 32'd1) : a;
        mag_b = (is_signed && b[31]) ? (~b + 32'd1) : b;
        q = mag_a / mag_b;
        r = mag_a % mag_b;
        if (is_signed && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (is_signed && a[31])           r = ~r + 32'd1;
        return '{hi: r, lo: q};
    endfunction

    // ---------------------------------------------------------------------
    // Control
    // ---------------------------------------------------------------------
    md_op_e     op;
    logic       cancel_w;
    logic       accept;
    logic       launch;
    logic       done;
    logic [CNT_W-1:0] load_val;

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    md_result_t  pend_q, pend_d;
    md_result_t  res;

`ifdef MD_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign op     = md_op_e'(md_op);
    // Starts are only honoured when idle; cancel masks any start on its edge.
    assign accept = start && !busy && !cancel_w;
    assign launch = accept && md_is_muldiv(op);

    assign load_val = ((op == MD_DIV) || (op == MD_DIVU)) ? CNT_W'(DIV_CYCLES)
                                                          : CNT_W'(MULT_CYCLES);

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_busy_counter (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (launch),
        .load_val_i (load_val),
        .clear_i    (cancel_w),
        .busy_o     (busy),
        .done_o     (done)
    );

    // ---------------------------------------------------------------------
    // Result computation and next state
    // ---------------------------------------------------------------------
    always_comb begin
        res = '{hi: hi_q, lo: lo_q};
        case (op)
            MD_MULT:  res = mul_signed(A, B);
            MD_MULTU: res = mul_unsigned(A, B);
            MD_DIV:   res = divide(A, B, 1'b1, '{hi: hi_q, lo: lo_q});
            MD_DIVU:  res = divide(A, B, 1'b0, '{hi: hi_q, lo: lo_q});
            default:  res = '{hi: hi_q, lo: lo_q};
        endcase
    end

    // done requires busy and accept requires !busy, so they never coincide.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        if (launch) begin
            pend_d = res;
        end
        if (done) begin
            hi_d = pend_q.hi;
            lo_d = pend_q.lo;
        end
        if (accept && (op == MD_MTHI)) hi_d = A;
        if (accept && (op == MD_MTLO)) lo_d = A;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_pass = 0;
    int n_total = 0;

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MD_CANCEL_EN
        .cancel (cancel),
`endif
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and count the busy cycles that follow (bounded at 64).
    // Enters and leaves 1 time unit after a rising edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cnt);
        start = 1'b1; md_op = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy && cnt < 64) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (hi_out !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", lo_out); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int cnt;
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, cnt);
        n_total++; if (cnt !== 5) $display("FAIL mult_busy_cycles: got %0d expected 5", cnt); else n_pass++;
        n_total++; if (hi_out !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'hFFFFFFFA) $display("FAIL mult_lo: got %h expected fffffffa", lo_out); else n_pass++;
    endtask

    task automatic test_multu();
        int cnt;
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, cnt);
        n_total++; if (cnt !== 5) $display("FAIL multu_busy_cycles: got %0d expected 5", cnt); else n_pass++;
        n_total++; if (hi_out !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h expected fffffffe", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'h00000001) $display("FAIL multu_lo: got %h expected 00000001", lo_out); else n_pass++;
    endtask

    task automatic test_div();
        int cnt;
        start = 1'b1; md_op = 3'd3; A = 32'hFFFFFFF9; B = 32'd2;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy && cnt < 64) begin
            cnt++;
            // HI/LO must still show the previous MULTU result until busy falls
            if (cnt == 9) begin
                n_total++; if (lo_out !== 32'h00000001) $display("FAIL div_lo_before_commit: got %h expected 00000001", lo_out); else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_total++; if (cnt !== 10) $display("FAIL div_busy_cycles: got %0d expected 10", cnt); else n_pass++;
        n_total++; if (lo_out !== 32'hFFFFFFFD) $display("FAIL div_lo: got %h expected fffffffd", lo_out); else n_pass++;
        n_total++; if (hi_out !== 32'hFFFFFFFF) $display("FAIL div_hi: got %h expected ffffffff", hi_out); else n_pass++;
    endtask

    task automatic test_divu();
        int cnt;
        run_op(3'd4, 32'd7, 32'd2, cnt);
        n_total++; if (cnt !== 10) $display("FAIL divu_busy_cycles: got %0d expected 10", cnt); else n_pass++;
        n_total++; if (lo_out !== 32'd3) $display("FAIL divu_lo: got %h expected 00000003", lo_out); else n_pass++;
        n_total++; if (hi_out !== 32'd1) $display("FAIL divu_hi: got %h expected 00000001", hi_out); else n_pass++;
    endtask

    task automatic test_div_overflow();
        int cnt;
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, cnt);
        n_total++; if (lo_out !== 32'h80000000) $display("FAIL div_ovf_lo: got %h expected 80000000", lo_out); else n_pass++;
        n_total++; if (hi_out !== 32'h0) $display("FAIL div_ovf_hi: got %h expected 00000000", hi_out); else n_pass++;
    endtask

    task automatic test_mthi_mtlo();
        int cnt;
        run_op(3'd5, 32'h11, 32'd0, cnt);
        n_total++; if (cnt !== 0) $display("FAIL mthi_busy: got %0d cycles expected 0", cnt); else n_pass++;
        run_op(3'd6, 32'h22, 32'd0, cnt);
        n_total++; if (hi_out !== 32'h11) $display("FAIL mthi_hi: got %h expected 00000011", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'h22) $display("FAIL mtlo_lo: got %h expected 00000022", lo_out); else n_pass++;
    endtask

    task automatic test_div_zero();
        int cnt;
        run_op(3'd4, 32'd99, 32'd0, cnt);
        n_total++; if (cnt !== 10) $display("FAIL divzero_busy_cycles: got %0d expected 10", cnt); else n_pass++;
        n_total++; if (hi_out !== 32'h11) $display("FAIL divzero_hi: got %h expected 00000011", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'h22) $display("FAIL divzero_lo: got %h expected 00000022", lo_out); else n_pass++;
    endtask

    task automatic test_mthi_abcd();
        int cnt;
        run_op(3'd5, 32'hABCD, 32'd0, cnt);
        n_total++; if (busy !== 1'b0) $display("FAIL mthi_abcd_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (hi_out !== 32'hABCD) $display("FAIL mthi_abcd_hi: got %h expected 0000abcd", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'h22) $display("FAIL mthi_abcd_lo: got %h expected 00000022", lo_out); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int cnt;
        start = 1'b1; md_op = 3'd4; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        cnt = 0;
        while (busy && cnt < 64) begin
            cnt++;
            if (cnt == 3) begin
                start = 1'b1; md_op = 3'd1; A = 32'd5; B = 32'd5;
            end else begin
                start = 1'b0; md_op = 3'd0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_total++; if (cnt !== 10) $display("FAIL busy_start_cycles: got %0d expected 10", cnt); else n_pass++;
        n_total++; if (lo_out !== 32'd14) $display("FAIL busy_start_lo: got %h expected 0000000e", lo_out); else n_pass++;
        n_total++; if (hi_out !== 32'd2) $display("FAIL busy_start_hi: got %h expected 00000002", hi_out); else n_pass++;
    endtask

    task automatic test_nop();
        int cnt;
        run_op(3'd0, 32'h1234, 32'h5678, cnt);
        run_op(3'd7, 32'h1234, 32'h5678, cnt);
        n_total++; if (busy !== 1'b0) $display("FAIL nop_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (hi_out !== 32'd2) $display("FAIL nop_hi: got %h expected 00000002", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'd14) $display("FAIL nop_lo: got %h expected 0000000e", lo_out); else n_pass++;
    endtask

`ifdef MD_CANCEL_EN
    task automatic test_cancel();
        int cnt;
        start = 1'b1; md_op = 3'd2; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        cnt = 1;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy) cnt++;
        end
        // Now in the 5th busy cycle; the coming edge would commit.
        n_total++; if (cnt !== 5) $display("FAIL cancel_pre_cycles: got %0d expected 5", cnt); else n_pass++;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL cancel_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (hi_out !== 32'd2) $display("FAIL cancel_hi: got %h expected 00000002", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'd14) $display("FAIL cancel_lo: got %h expected 0000000e", lo_out); else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_op();
        start = 1'b1; md_op = 3'd4; A = 32'd50; B = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; md_op = 3'd0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        n_total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (hi_out !== 32'h0) $display("FAIL rstmid_hi: got %h expected 00000000", hi_out); else n_pass++;
        n_total++; if (lo_out !== 32'h0) $display("FAIL rstmid_lo: got %h expected 00000000", lo_out); else n_pass++;
        repeat (12) @(posedge clk);
        #1;
        n_total++; if (lo_out !== 32'h0) $display("FAIL rstmid_no_commit: got %h expected 00000000", lo_out); else n_pass++;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; cancel = 1'b0; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divu();
        test_div_overflow();
        test_mthi_mtlo();
        test_div_zero();
        test_mthi_abcd();
        test_start_while_busy();
        test_nop();
`ifdef MD_CANCEL_EN
        test_cancel();
`endif
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
